// File: rtl/hilo_ctrl.sv
// HI/LO register pair with multiply sequencing: issues operands and a start pulse
// to the Booth multiplier, stalls until it finishes, then commits the product.
module hilo_ctrl #(
  parameter int TIMEOUT = 40
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        op_valid,
  input  logic [1:0]  op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  output logic        w_MultStart,
  output logic [31:0] w_A,
  output logic [31:0] w_B,
  input  logic        w_MultStop,
  input  logic [31:0] w_MULTHI,
  input  logic [31:0] w_MULTLO,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy,
  output logic        done,
  output logic        err
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_WAIT,
    S_WRITE
  } state_t;

  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_MTHI  = 2'b10;
  localparam logic [1:0] OP_MTLO  = 2'b11;

  localparam int            CW      = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  state_t        state;
  logic [CW-1:0] cnt;
  logic          is_unsigned;
  logic [31:0]   corr;

  // Turns the signed high word into the unsigned one: add the operand once for
  // each operand whose top bit the signed multiplier treated as negative.
  always_comb begin
    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    corr = '0;
    if (is_unsigned) begin
      corr = (w_A[31] ? w_B : 32'd0) + (w_B[31] ? w_A : 32'd0);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state       <= S_IDLE;
      cnt         <= '0;
      is_unsigned <= 1'b0;
      w_MultStart <= 1'b0;
      w_A         <= '0;
      w_B         <= '0;
      hi          <= '0;
      lo          <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
    end else begin
      w_MultStart <= 1'b0;
      done        <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (op_valid) begin
            case (op)
              OP_MTHI: hi <= rs_val;
              OP_MTLO: lo <= rs_val;
              default: begin
                w_A         <= rs_val;
                w_B         <= rt_val;
                is_unsigned <= (op == OP_MULTU);
                w_MultStart <= 1'b1;
                busy        <= 1'b1;
                state       <= S_START;
              end
            endcase
          end
        end
        S_START: begin
          cnt   <= '0;
          state <= S_WAIT;
        end
        S_WAIT: begin
          cnt <= cnt + CNT_ONE;
          // A stop arriving on the last allowed cycle still counts as success.
          if (w_MultStop) begin
            state <= S_WRITE;
          end else if (cnt + CNT_ONE == CNT_MAX) begin
            err   <= 1'b1;
            busy  <= 1'b0;
            state <= S_IDLE;
          end
        end
        S_WRITE: begin
          lo    <= w_MULTLO;
          hi    <= w_MULTHI + corr;
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hilo_ctrl.sv
// Bench for hilo_ctrl: behavioural Mult stub with programmable latency, directed
// operations, and a scoreboard checked by a monitor whenever done pulses.
module tb_hilo_ctrl;

  localparam int TIMEOUT = 40;

  logic        Clock;
  logic        Reset;
  logic        op_valid;
  logic [1:0]  op;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        w_MultStart;
  logic [31:0] w_A;
  logic [31:0] w_B;
  logic        w_MultStop;
  logic [31:0] w_MULTHI;
  logic [31:0] w_MULTLO;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        done;
  logic        err;

  hilo_ctrl #(.TIMEOUT(TIMEOUT)) dut (
    .Clock(Clock), .Reset(Reset), .op_valid(op_valid), .op(op),
    .rs_val(rs_val), .rt_val(rt_val), .w_MultStart(w_MultStart),
    .w_A(w_A), .w_B(w_B), .w_MultStop(w_MultStop),
    .w_MULTHI(w_MULTHI), .w_MULTLO(w_MULTLO), .hi(hi), .lo(lo),
    .busy(busy), .done(done), .err(err)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   n_done   = 0;
  logic prev_start = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // Signed multiplier stub: latency 0 means it never finishes.
  int          mult_lat = 32;
  int          m_cnt    = 0;
  logic [63:0] m_prod   = '0;
  initial begin
    w_MultStop = 1'b0;
    w_MULTHI   = '0;
    w_MULTLO   = '0;
  end
  always @(posedge Clock) begin
    if (w_MultStart) begin
      w_MultStop <= 1'b0;
      m_cnt      <= mult_lat;
      m_prod     <= $signed({{32{w_A[31]}}, w_A}) * $signed({{32{w_B[31]}}, w_B});
    end else if (m_cnt > 0) begin
      m_cnt <= m_cnt - 1;
      if (m_cnt == 1) begin
        w_MultStop <= 1'b1;
        w_MULTHI   <= m_prod[63:32];
        w_MULTLO   <= m_prod[31:0];
      end
    end
  end

  // Monitor: compare HI/LO against the scoreboard on every done pulse.
  always @(negedge Clock) begin
    if (!Reset) begin
      if (done) begin
        n_done++;
        check("sb_has_entry", 64'(sb.size() != 0), 64'd1);
        if (sb.size() != 0) begin
          exp_t e;
          e = sb.pop_front();
          check("commit_hi", 64'(hi), 64'(e.hi));
          check("commit_lo", 64'(lo), 64'(e.lo));
        end
      end
      if (w_MultStart) check("start_single_cycle", 64'(prev_start), 64'd0);
      prev_start = w_MultStart;
    end
  end

  task automatic move_to(input logic [1:0] o, input logic [31:0] v,
                         input logic [31:0] exp_hi, input logic [31:0] exp_lo, input logic exp_err);
    @(negedge Clock);
    op_valid = 1'b1; op = o; rs_val = v; rt_val = 32'h5555_5555;
    @(negedge Clock);
    op_valid = 1'b0;
    check("mt_hi", 64'(hi), 64'(exp_hi));
    check("mt_lo", 64'(lo), 64'(exp_lo));
    check("mt_busy", 64'(busy), 64'd0);
    check("mt_err", 64'(err), 64'(exp_err));
  endtask

  task automatic run_mult(input string nm, input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          input int lat, input bit exp_done, input logic [31:0] exp_hi,
                          input logic [31:0] exp_lo, input logic exp_err);
    int busy_cyc;
    int starts;
    int done_before;
    int exp_cyc;
    exp_t e;
    busy_cyc = 0;
    starts   = 0;
    exp_cyc  = exp_done ? lat + 3 : TIMEOUT + 1;
    if (exp_done) begin
      e.hi = exp_hi;
      e.lo = exp_lo;
      sb.push_back(e);
    end
    mult_lat    = lat;
    done_before = n_done;
    @(negedge Clock);
    op_valid = 1'b1; op = o; rs_val = a; rt_val = b;
    @(negedge Clock);
    op_valid = 1'b0;
    while (busy && busy_cyc < 200) begin
      busy_cyc++;
      if (w_MultStart) starts++;
      @(negedge Clock);
    end
    @(negedge Clock);
    $display("%s: busy for %0d cycles", nm, busy_cyc);
    check({nm, "_busy_cycles"}, 64'(busy_cyc), 64'(exp_cyc));
    check({nm, "_start_pulses"}, 64'(starts), 64'd1);
    check({nm, "_done_pulses"}, 64'(n_done - done_before), 64'(exp_done ? 1 : 0));
    check({nm, "_err"}, 64'(err), 64'(exp_err));
    check({nm, "_wa_held"}, 64'(w_A), 64'(a));
    check({nm, "_wb_held"}, 64'(w_B), 64'(b));
    if (!exp_done) begin
      check({nm, "_hi_kept"}, 64'(hi), 64'(exp_hi));
      check({nm, "_lo_kept"}, 64'(lo), 64'(exp_lo));
    end
  endtask

  initial begin
    Reset = 1'b1; op_valid = 1'b0; op = 2'b00; rs_val = '0; rt_val = '0;
    repeat (2) @(negedge Clock);
    check("rst_hi", 64'(hi), 64'd0);
    check("rst_lo", 64'(lo), 64'd0);
    check("rst_busy_done_err_start", 64'({busy, done, err, w_MultStart}), 64'd0);
    check("rst_wa_wb", {w_A, w_B}, 64'd0);
    Reset = 1'b0;

    move_to(2'b10, 32'h1234_5678, 32'h1234_5678, 32'h0000_0000, 1'b0);
    move_to(2'b11, 32'h9ABC_DEF0, 32'h1234_5678, 32'h9ABC_DEF0, 1'b0);

    run_mult("mult_7_m3",  2'b00, 32'd7, 32'hFFFF_FFFD, 32, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0);
    run_mult("multu_max",  2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32, 1'b1, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
    run_mult("multu_msb",  2'b01, 32'h8000_0000, 32'd2, 32, 1'b1, 32'h0000_0001, 32'h0000_0000, 1'b0);
    run_mult("mult_last_cycle", 2'b00, 32'd5, 32'd6, TIMEOUT - 1, 1'b1, 32'h0, 32'h1E, 1'b0);

    // Reset mid-WAIT must clear everything asynchronously.
    mult_lat = 32;
    @(negedge Clock);
    op_valid = 1'b1; op = 2'b00; rs_val = 32'd3; rt_val = 32'd4;
    @(negedge Clock);
    op_valid = 1'b0;
    repeat (10) @(negedge Clock);
    check("pre_reset_busy", 64'(busy), 64'd1);
    #2 Reset = 1'b1;
    #1;
    check("async_rst_hi_lo", {hi, lo}, 64'd0);
    check("async_rst_wa_wb", {w_A, w_B}, 64'd0);
    check("async_rst_flags", 64'({busy, done, err, w_MultStart}), 64'd0);
    @(negedge Clock);
    Reset = 1'b0;
    run_mult("mult_after_rst", 2'b00, 32'd3, 32'd4, 32, 1'b1, 32'h0, 32'd12, 1'b0);

    // Timeouts leave HI/LO alone and set a sticky err.
    move_to(2'b10, 32'hCAFE_F00D, 32'hCAFE_F00D, 32'd12, 1'b0);
    move_to(2'b11, 32'h0BAD_BEEF, 32'hCAFE_F00D, 32'h0BAD_BEEF, 1'b0);
    run_mult("timeout_never", 2'b00, 32'd9, 32'd9, 0, 1'b0, 32'hCAFE_F00D, 32'h0BAD_BEEF, 1'b1);
    run_mult("timeout_late",  2'b01, 32'd2, 32'd2, TIMEOUT, 1'b0, 32'hCAFE_F00D, 32'h0BAD_BEEF, 1'b1);
    move_to(2'b11, 32'h0000_0042, 32'hCAFE_F00D, 32'h0000_0042, 1'b1);
    repeat (3) @(negedge Clock);
    check("err_sticky", 64'(err), 64'd1);
    Reset = 1'b1;
    @(negedge Clock);
    check("err_cleared", 64'(err), 64'd0);
    Reset = 1'b0;

    // Stop is still high from the late multiply when this one starts.
    check("stale_stop_high", 64'(w_MultStop), 64'd1);
    run_mult("multu_stale_stop", 2'b01, 32'hFFFF_FFFE, 32'd3, 32, 1'b1, 32'h0000_0002, 32'hFFFF_FFFA, 1'b0);

    repeat (2) @(negedge Clock);
    check("sb_drained", 64'(sb.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/hilo_ctrl.md
# hilo_ctrl

Sequencing and storage unit for the HI/LO register pair, sitting directly upstream of the 32-cycle Booth multiplier `Mult` and consuming its results. It accepts MULT, MULTU, MTHI and MTLO requests from the control unit, issues the one-cycle start pulse and operands to `Mult`, and stalls the pipeline until `w_MultStop`. It then writes the product into HI/LO, applying an unsigned correction for MULTU, and presents HI/LO continuously for MFHI/MFLO.

## Interface
Parameters:
- `TIMEOUT`, 40: maximum WAIT cycles allowed before the operation is abandoned.

Ports:
- `Clock`  in  1  system clock; all state updates on the rising edge.
- `Reset`  in  1  asynchronous, active-high reset.
- `op_valid`  in  1  request strobe; sampled only in IDLE.
- `op`  in  2  00 MULT, 01 MULTU, 10 MTHI, 11 MTLO.
- `rs_val`  in  32  first operand; also the MTHI/MTLO data.
- `rt_val`  in  32  second operand.
- `w_MultStart`  out  1  one-cycle start pulse to `Mult`.
- `w_A`  out  32  multiplicand to `Mult`, registered.
- `w_B`  out  32  multiplier to `Mult`, registered.
- `w_MultStop`  in  1  completion flag from `Mult`.
- `w_MULTHI`  in  32  signed product, high word.
- `w_MULTLO`  in  32  signed product, low word.
- `hi`  out  32  HI register.
- `lo`  out  32  LO register.
- `busy`  out  1  pipeline stall; high whenever state ≠ IDLE.
- `done`  out  1  one-cycle pulse when a multiply commits to HI/LO.
- `err`  out  1  sticky timeout flag; cleared only by reset.

## Operation
- Reset (asynchronous) forces the state to IDLE and drives every output to 0: `hi`, `lo`, `w_A`, `w_B`, `w_MultStart`, `busy`, `done`, `err`. Any multiply in flight is abandoned.
- States and transitions:
  - IDLE, with `op_valid`=1:
    - `op`=10: `hi`←`rs_val`; stay in IDLE.
    - `op`=11: `lo`←`rs_val`; stay in IDLE.
    - `op`=00 or 01: `w_A`←`rs_val`, `w_B`←`rt_val`; latch an unsigned flag (1 for 01); go to START.
  - START: `w_MultStart`=1 for exactly this cycle; clear the cycle counter; go to WAIT.
  - WAIT: counter increments each cycle.
    - `w_MultStop`=1: go to WRITE.
    - Otherwise, counter reaches `TIMEOUT`: set `err`; HI/LO remain unchanged; go to IDLE.
    - `w_MultStop` wins if both conditions occur in the same cycle.
  - WRITE: `lo`←`w_MULTLO` and `hi`←`w_MULTHI` + corr, mod 2^32; `done`=1; go to IDLE.
- MULTU correction: corr = (`w_A`[31] ? `w_B` : 0) + (`w_B`[31] ? `w_A` : 0), mod 2^32. For MULT, corr = 0. `lo` is never corrected.
- `w_MultStop` is high on entry to START when left over from the previous multiply. `Mult` clears it on the start edge, so it is evaluated only in WAIT.
- `op_valid` outside IDLE is ignored. The control unit holds the request while `busy`=1, and `busy` covers START, WAIT and WRITE.
- `w_A` and `w_B` hold their values after the operation completes.

## Timing
- MTHI/MTLO: 1 cycle. The new value is visible on `hi`/`lo` after the accepting edge; `busy` stays 0.
- MULT/MULTU:
  - Edge 0 (accept): state → START; `busy`=1.
  - Edge 1: `w_MultStart` is sampled by `Mult`.
  - Edge 1+N: WAIT sees `w_MultStop` rise after N cycles, N=32 for the nominal `Mult`.
  - Next edge: WRITE commits `hi`/`lo`, `done`=1 for that cycle, and `busy` drops on the following edge.
  - Total ≈ N+3 cycles.
- `w_MultStart` is never high for more than one consecutive cycle.
- An MFHI/MFLO reading `hi`/`lo` in the cycle `done`=1 sees the new values.

## Test plan
- Reset: assert `Reset` mid-WAIT → all outputs 0 within the same cycle and state IDLE; the following MULT operates normally.
- MTHI 0x12345678, then MTLO 0x9ABCDEF0 → `hi`=0x12345678, `lo`=0x9ABCDEF0; `busy` never rises.
- MULT 7 × 0xFFFFFFFD (−3) → `hi`=0xFFFFFFFF, `lo`=0xFFFFFFEB; `done` pulses once; `w_MultStart` high for exactly 1 cycle.
- MULTU 0xFFFFFFFF × 0xFFFFFFFF → `hi`=0xFFFFFFFE, `lo`=0x00000001.
- MULTU 0x80000000 × 2 → `hi`=0x00000001, `lo`=0x00000000.
- Stub `Mult` that never asserts `w_MultStop`, with `TIMEOUT`=40 → `err`=1 after 40 WAIT cycles; `hi`/`lo` unchanged; back in IDLE; `err` stays set until `Reset`.
